xor2_gate: RTL and testbench



---
 rtl/xor2_gate.sv | 43 ++++
 tb/tb_xor2_gate.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor2_gate.sv
// Bitwise two-input XOR with a zero-latency combinational result and a clocked
// side path: registered result, any-bit-differs flag and a saturating difference counter.
module xor2_gate #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             any_q,
    output logic [CNT_W-1:0] diff_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] diff_c;
    logic             any_c;

    // Combinational path stays free of clk/rst/en so it works as plain glue logic.
    assign diff_c = a ^ b;
    assign any_c  = |diff_c;
    assign y      = diff_c;

    // Clocked side path; reset wins over enable, counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= '0;
            any_q    <= 1'b0;
            diff_cnt <= '0;
        end else if (en) begin
            y_q   <= diff_c;
            any_q <= any_c;
            if (any_c && (diff_cnt != CNT_MAX)) begin
                diff_cnt <= diff_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xor2_gate.sv
// Randomised self-checking bench for xor2_gate: a 4-bit/8-bit-counter instance and
// a 1-bit/2-bit-counter instance, both compared against a behavioural model.
module tb_xor2_gate;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;

    logic       rst4, en4;
    logic [3:0] a4, b4, y4, yq4;
    logic       any4;
    logic [7:0] cnt4;

    logic       rst1, en1;
    logic [0:0] a1, b1, y1, yq1;
    logic       any1;
    logic [1:0] cnt1;

    int total = 0;
    int bad   = 0;

    int m4_yq, m4_any, m4_cnt;
    int m1_yq, m1_any, m1_cnt;

    xor2_gate #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst4), .a(a4), .b(b4), .en(en4),
        .y(y4), .y_q(yq4), .any_q(any4), .diff_cnt(cnt4)
    );

    xor2_gate #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .en(en1),
        .y(y1), .y_q(yq1), .any_q(any1), .diff_cnt(cnt1)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Model: advance both reference states from the inputs present at the edge.
    task automatic edge_step();
        int d4, d1;
        d4 = int'(a4) ^ int'(b4);
        d1 = int'(a1) ^ int'(b1);
        if (rst4) begin
            m4_yq = 0; m4_any = 0; m4_cnt = 0;
        end else if (en4) begin
            m4_yq  = d4;
            m4_any = (d4 != 0) ? 1 : 0;
            if (d4 != 0) m4_cnt = (m4_cnt + 1 > 255) ? 255 : m4_cnt + 1;
        end
        if (rst1) begin
            m1_yq = 0; m1_any = 0; m1_cnt = 0;
        end else if (en1) begin
            m1_yq  = d1;
            m1_any = (d1 != 0) ? 1 : 0;
            if (d1 != 0) m1_cnt = (m1_cnt + 1 > 3) ? 3 : m1_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_both();
        rst4 = 1'b1; rst1 = 1'b1;
        edge_step();
        rst4 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_truth_table();
        int exp_y;
        for (int i = 0; i < 4; i++) begin
            a1 = 1'((i >> 1) & 1);
            b1 = 1'(i & 1);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            #1;
            exp_y = ((i >> 1) & 1) ^ (i & 1);
            total++;
            if (y1 !== 1'(exp_y)) begin
                bad++;
                $display("FAIL truth_table ab=%0d%0d y got=%b exp=%0d", a1, b1, y1, exp_y);
            end
            exp_y = int'(a4) ^ int'(b4);
            total++;
            if (y4 !== 4'(exp_y)) begin
                bad++;
                $display("FAIL truth_table_w4 y got=%h exp=%h", y4, exp_y);
            end
            #9;
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst1 = 1'b1; en4 = 1'b1; en1 = 1'b1;
        a4 = 4'b1100; b4 = 4'b1010; a1 = 1'b1; b1 = 1'b0;
        #1;
        total++;
        if (y4 !== 4'b0110) begin
            bad++;
            $display("FAIL reset_y_indep got=%b exp=0110", y4);
        end
        edge_step();
        total++;
        if (yq4 !== 4'd0 || any4 !== 1'b0 || cnt4 !== 8'd0) begin
            bad++;
            $display("FAIL reset_w4 yq=%h any=%b cnt=%0d exp all 0", yq4, any4, cnt4);
        end
        total++;
        if (yq1 !== 1'b0 || any1 !== 1'b0 || cnt1 !== 2'd0) begin
            bad++;
            $display("FAIL reset_w1 yq=%b any=%b cnt=%0d exp all 0", yq1, any1, cnt1);
        end
        rst4 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_single_edge();
        en4 = 1'b1; a4 = 4'b0001; b4 = 4'b0000;
        #1;
        total++;
        if (yq4 !== 4'd0 || any4 !== 1'b0 || cnt4 !== 8'd0) begin
            bad++;
            $display("FAIL single_pre yq=%h any=%b cnt=%0d exp 0", yq4, any4, cnt4);
        end
        edge_step();
        total++;
        if (yq4 !== 4'd1 || any4 !== 1'b1 || cnt4 !== 8'd1) begin
            bad++;
            $display("FAIL single_post yq=%h any=%b cnt=%0d exp 1/1/1", yq4, any4, cnt4);
        end
    endtask

    task automatic test_enable_hold();
        reset_both();
        en4 = 1'b0; a4 = 4'b0001; b4 = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            total++;
            if (yq4 !== 4'd0 || any4 !== 1'b0 || cnt4 !== 8'd0 || y4 !== 4'd1) begin
                bad++;
                $display("FAIL enable_hold edge=%0d yq=%h any=%b cnt=%0d y=%h", i, yq4, any4, cnt4, y4);
            end
        end
    endtask

    task automatic test_saturation();
        int seq [6] = '{1, 2, 3, 3, 3, 3};
        reset_both();
        en1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            edge_step();
            total++;
            if (cnt1 !== 2'(seq[i]) || m1_cnt != seq[i]) begin
                bad++;
                $display("FAIL saturation edge=%0d cnt got=%0d exp=%0d", i, cnt1, seq[i]);
            end
        end
    endtask

    task automatic test_width4();
        reset_both();
        en4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
        #1;
        total++;
        if (y4 !== 4'b0110) begin
            bad++;
            $display("FAIL w4_comb y got=%b exp=0110", y4);
        end
        edge_step();
        total++;
        if (yq4 !== 4'b0110 || any4 !== 1'b1 || cnt4 !== 8'd1) begin
            bad++;
            $display("FAIL w4_reg yq=%b any=%b cnt=%0d exp 0110/1/1", yq4, any4, cnt4);
        end
        a4 = 4'b0101; b4 = 4'b0101;
        #1;
        total++;
        if (y4 !== 4'b0000) begin
            bad++;
            $display("FAIL w4_equal_comb y got=%b exp=0000", y4);
        end
        edge_step();
        total++;
        if (yq4 !== 4'b0000 || any4 !== 1'b0 || cnt4 !== 8'd1) begin
            bad++;
            $display("FAIL w4_equal_reg yq=%b any=%b cnt=%0d exp 0000/0/1", yq4, any4, cnt4);
        end
    endtask

    task automatic test_reset_mid_count();
        reset_both();
        en4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a4 = 4'($urandom_range(1, 15)); b4 = 4'd0;
            edge_step();
        end
        total++;
        if (cnt4 !== 8'd5) begin
            bad++;
            $display("FAIL mid_count_pre cnt got=%0d exp=5", cnt4);
        end
        rst4 = 1'b1; a4 = 4'b1111; b4 = 4'b0000;
        edge_step();
        rst4 = 1'b0;
        total++;
        if (yq4 !== 4'd0 || any4 !== 1'b0 || cnt4 !== 8'd0) begin
            bad++;
            $display("FAIL mid_count_reset yq=%h any=%b cnt=%0d exp all 0", yq4, any4, cnt4);
        end
    endtask

    task automatic test_random();
        int exp_y;
        reset_both();
        for (int i = 0; i < 400; i++) begin
            a4 = 4'($urandom); b4 = ($urandom_range(0, 3) == 0) ? a4 : 4'($urandom);
            en4 = ($urandom_range(0, 3) != 0); rst4 = ($urandom_range(0, 63) == 0);
            a1 = 1'($urandom); b1 = 1'($urandom);
            en1 = ($urandom_range(0, 3) != 0); rst1 = ($urandom_range(0, 31) == 0);
            #1;
            exp_y = int'(a4) ^ int'(b4);
            total++;
            if (y4 !== 4'(exp_y) || y1 !== 1'(int'(a1) ^ int'(b1))) begin
                bad++;
                $display("FAIL random_comb i=%0d y4=%h exp=%h y1=%b", i, y4, exp_y, y1);
            end
            edge_step();
            total++;
            if (yq4 !== 4'(m4_yq) || any4 !== 1'(m4_any) || cnt4 !== 8'(m4_cnt)) begin
                bad++;
                $display("FAIL random_w4 i=%0d yq=%h/%h any=%b/%0d cnt=%0d/%0d",
                         i, yq4, m4_yq, any4, m4_any, cnt4, m4_cnt);
            end
            total++;
            if (yq1 !== 1'(m1_yq) || any1 !== 1'(m1_any) || cnt1 !== 2'(m1_cnt)) begin
                bad++;
                $display("FAIL random_w1 i=%0d yq=%b/%0d any=%b/%0d cnt=%0d/%0d",
                         i, yq1, m1_yq, any1, m1_any, cnt1, m1_cnt);
            end
        end
        rst4 = 1'b0; rst1 = 1'b0;
    endtask

    initial begin
        rst4 = 1'b0; en4 = 1'b0; a4 = '0; b4 = '0;
        rst1 = 1'b0; en1 = 1'b0; a1 = '0; b1 = '0;
        m4_yq = 0; m4_any = 0; m4_cnt = 0;
        m1_yq = 0; m1_any = 0; m1_cnt = 0;
        test_truth_table();
        clk_run = 1'b1;
        test_reset();
        test_single_edge();
        test_enable_hold();
        test_saturation();
        test_width4();
        test_reset_mid_count();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
